id_ex_reg: RTL

//  Decode-to-execute pipeline register, directly downstream of the fetch/decode register.

---
 rtl/id_ex_reg.sv | 115 +++++++++++
 1 files changed

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register: captures the decoded instruction each cycle,
// inserts bubbles on decode stall, flushes to the handler entry, merges exceptions and ages Tnew.
module id_ex_reg #(
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter int          TNEW_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              D_stall,
  input  logic [31:0]       D_pc,
  input  logic [31:0]       D_instr,
  input  logic [31:0]       D_rs_data,
  input  logic [31:0]       D_rt_data,
  input  logic [31:0]       D_ext,
  input  logic [TNEW_W-1:0] D_tnew,
  input  logic [3:0]        D_excCode,
  input  logic              D_ri,
  input  logic              D_syscall,
  input  logic              D_bd,
  output logic [31:0]       E_pc,
  output logic [31:0]       E_instr,
  output logic [31:0]       E_rs_data,
  output logic [31:0]       E_rt_data,
  output logic [31:0]       E_ext,
  output logic [TNEW_W-1:0] E_tnew,
  output logic [3:0]        E_excCode,
  output logic              E_bd,
  output logic              E_valid
);

  typedef enum logic [3:0] {
    EXC_NONE    = 4'd0,
    EXC_SYSCALL = 4'd8,
    EXC_RI      = 4'd10
  } exc_code_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [31:0]       ext;
    logic [TNEW_W-1:0] tnew;
    logic [3:0]        exc_code;
    logic              bd;
    logic              valid;
  } ex_stage_t;

  ex_stage_t         r_stage;
  ex_stage_t         w_next;
  logic [3:0]        w_exc_code;
  logic              w_kill_instr;
  logic [TNEW_W-1:0] w_tnew_aged;

  // Fetch-side exceptions outrank decode-side ones; RI and fetch faults turn the word into a nop,
  // while syscall keeps its encoding so the handler can decode the call.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_exc_code   = EXC_NONE;
    w_kill_instr = 1'b0;
    if (D_excCode != 4'd0) begin
      w_exc_code   = D_excCode;
      w_kill_instr = 1'b1;
    end else if (D_ri) begin
      w_exc_code   = EXC_RI;
      w_kill_instr = 1'b1;
    end else if (D_syscall) begin
      w_exc_code   = EXC_SYSCALL;
    end
  end

  assign w_tnew_aged = (D_tnew == '0) ? '0 : D_tnew - TNEW_W'(1);

  always_comb begin
    w_next = '0;
    if (req) begin
      w_next.pc = EXC_ENTRY;
    end else if (D_stall) begin
      // The bubble keeps PC and BD so an interrupt landing on it reports the right EPC.
      w_next.pc = D_pc;
      w_next.bd = D_bd;
    end else begin
      w_next.pc       = D_pc;
      w_next.instr    = w_kill_instr ? 32'd0 : D_instr;
      w_next.rs_data  = D_rs_data;
      w_next.rt_data  = D_rt_data;
      w_next.ext      = D_ext;
      w_next.tnew     = w_tnew_aged;
      w_next.exc_code = w_exc_code;
      w_next.bd       = D_bd;
      w_next.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stage <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops sample together.
      r_stage <= w_next;
    end
  end

  assign E_pc      = r_stage.pc;
  assign E_instr   = r_stage.instr;
  assign E_rs_data = r_stage.rs_data;
  assign E_rt_data = r_stage.rt_data;
  assign E_ext     = r_stage.ext;
  assign E_tnew    = r_stage.tnew;
  assign E_excCode = r_stage.exc_code;
  assign E_bd      = r_stage.bd;
  assign E_valid   = r_stage.valid;

endmodule
